// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC lane array.
package mac_pkg;

  typedef enum logic [1:0] {
    MODE_INT8 = 2'b00,
    MODE_INT4 = 2'b01,
    MODE_VSQ  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  localparam int unsigned DOT_W            = 22;
  localparam int unsigned GROUP_ELEMS      = 16;
  localparam int unsigned CHUNK_BITS       = 256;
  localparam int unsigned GROUP_BITS       = GROUP_ELEMS * 4;
  localparam int unsigned GROUPS_PER_CHUNK = CHUNK_BITS / GROUP_BITS;

  function automatic logic signed [31:0] sx8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  function automatic logic signed [31:0] sx4(input logic [3:0] v);
    return {{28{v[3]}}, v};
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: mode-dependent dot product, S1 dot register, S2 accumulator/result.
// MAC_SAT_EN selects saturating accumulation with a sticky per-sequence flag.
module mac_lane
  import mac_pkg::*;
#(
  parameter int unsigned VEC_BITS = 256,
  parameter int unsigned ACC_W    = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    adv,
  input  logic                    in_take,
  input  logic                    s1_valid,
  input  logic                    s1_first,
  input  logic                    s1_last,
  input  logic [1:0]              mode,
  input  logic [VEC_BITS-1:0]     vec_a,
  input  logic [VEC_BITS-1:0]     vec_b,
  input  logic [15:0]             scale_a,
  input  logic [15:0]             scale_b,
  output logic signed [ACC_W-1:0] result,
  output logic                    sat
);

  localparam int unsigned N8    = VEC_BITS / 8;
  localparam int unsigned N4    = VEC_BITS / 4;
  localparam int unsigned NG    = VEC_BITS / GROUP_BITS;
  localparam int unsigned SUM_W = ACC_W + 1;

  logic signed [31:0]      sum8, sum4, sumv, part, scl;
  logic signed [DOT_W-1:0] dot_c, dot_d, dot_q;
  logic signed [ACC_W-1:0] base_c, dext_c, acc_new_c;
  logic signed [ACC_W-1:0] acc_d, acc_q, res_d, res_q;
  logic                    acc_en;

  assign acc_en = adv && s1_valid;

  // Dot product for all three element formats; mode picks one.
  always_comb begin
    sum8  = '0;
    sum4  = '0;
    sumv  = '0;
    part  = '0;
    scl   = '0;
    dot_c = '0;
    for (int e = 0; e < int'(N8); e++)
      sum8 = sum8 + sx8(vec_a[e*8 +: 8]) * sx8(vec_b[e*8 +: 8]);
    for (int e = 0; e < int'(N4); e++)
      sum4 = sum4 + sx4(vec_a[e*4 +: 4]) * sx4(vec_b[e*4 +: 4]);
    for (int g = 0; g < int'(NG); g++) begin
      part = '0;
      for (int e = 0; e < int'(GROUP_ELEMS); e++)
        part = part + sx4(vec_a[(g*int'(GROUP_ELEMS)+e)*4 +: 4])
                    * sx4(vec_b[(g*int'(GROUP_ELEMS)+e)*4 +: 4]);
      scl  = $signed({28'd0, scale_a[(g % int'(GROUPS_PER_CHUNK))*4 +: 4]})
           * $signed({28'd0, scale_b[(g % int'(GROUPS_PER_CHUNK))*4 +: 4]});
      sumv = sumv + part * scl;
    end
    case (mode_t'(mode))
      MODE_INT8: dot_c = DOT_W'(sum8);
      MODE_INT4: dot_c = DOT_W'(sum4);
      MODE_VSQ:  dot_c = DOT_W'(sumv);
      default:   dot_c = '0;
    endcase
  end

`ifdef MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic signed [SUM_W-1:0] sum_c;
  logic                    ovf_c, sat_new_c;
  logic                    sat_run_d, sat_run_q, sat_res_d, sat_res_q;
`endif

  always_comb begin
    dot_d  = in_take ? dot_c : dot_q;
    base_c = s1_first ? '0 : acc_q;
    dext_c = ACC_W'(dot_q);
`ifdef MAC_SAT_EN
    // One guard bit is enough: both addends fit ACC_W signed.
    sum_c     = SUM_W'(base_c) + SUM_W'(dext_c);
    ovf_c     = sum_c[ACC_W] ^ sum_c[ACC_W-1];
    acc_new_c = ovf_c ? (sum_c[ACC_W] ? ACC_MIN : ACC_MAX) : sum_c[ACC_W-1:0];
    sat_new_c = (s1_first ? 1'b0 : sat_run_q) | ovf_c;
`else
    acc_new_c = base_c + dext_c;
`endif
    acc_d = acc_en ? acc_new_c : acc_q;
    res_d = (acc_en && s1_last) ? acc_new_c : res_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dot_q <= '0;
      acc_q <= '0;
      res_q <= '0;
    end else begin
      dot_q <= dot_d;
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign result = res_q;

`ifdef MAC_SAT_EN
  always_comb begin
    sat_run_d = acc_en ? sat_new_c : sat_run_q;
    sat_res_d = (acc_en && s1_last) ? sat_new_c : sat_res_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_run_q <= 1'b0;
      sat_res_q <= 1'b0;
    end else begin
      sat_run_q <= sat_run_d;
      sat_res_q <= sat_res_d;
    end
  end

  assign sat = sat_res_q;
`else
  assign sat = 1'b0;
`endif

endmodule

// File: rtl/mac_lane_array.sv
// LANES parallel MAC lanes sharing one broadcast B vector and a 2-stage stall-able pipeline.
// Define MAC_SAT_EN for saturating accumulation; otherwise accumulators wrap.
module mac_lane_array
  import mac_pkg::*;
#(
  parameter int unsigned LANES    = 16,
  parameter int unsigned VEC_BITS = 256,
  parameter int unsigned ACC_W    = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_first,
  input  logic                      in_last,
  input  logic [1:0]                mode,
  input  logic [LANES*VEC_BITS-1:0] vec_a,
  input  logic [VEC_BITS-1:0]       vec_b,
  input  logic [LANES*16-1:0]       scale_a,
  input  logic [15:0]               scale_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*ACC_W-1:0]    out_result,
  output logic [LANES-1:0]          out_sat
);

  logic adv_c, take_c;
  logic s1_valid_d, s1_valid_q;
  logic s1_first_d, s1_first_q;
  logic s1_last_d, s1_last_q;
  logic out_valid_d, out_valid_q;

  // Whole pipeline freezes only while a result waits on the consumer.
  assign adv_c    = !(out_valid_q && !out_ready);
  assign take_c   = adv_c && in_valid;
  assign in_ready = adv_c;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    if (adv_c) begin
      s1_valid_d  = in_valid;
      s1_first_d  = in_first;
      s1_last_d   = in_last;
      out_valid_d = s1_valid_q && s1_last_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

  for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
    mac_lane #(
      .VEC_BITS (VEC_BITS),
      .ACC_W    (ACC_W)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (adv_c),
      .in_take  (take_c),
      .s1_valid (s1_valid_q),
      .s1_first (s1_first_q),
      .s1_last  (s1_last_q),
      .mode     (mode),
      .vec_a    (vec_a[i*VEC_BITS +: VEC_BITS]),
      .vec_b    (vec_b),
      .scale_a  (scale_a[i*16 +: 16]),
      .scale_b  (scale_b),
      .result   (out_result[i*ACC_W +: ACC_W]),
      .sat      (out_sat[i])
    );
  end

endmodule

// File: doc/mac_lane_array.md
MAC_LANE_ARRAY -- requirements
Module: mac_lane_array

Interface
REQ-001 SHALL have parameter LANES, default 16, giving the number of parallel MAC lanes.
REQ-002 SHALL have parameter VEC_BITS, default 256, giving the operand vector width; it SHALL be a multiple of 64.
REQ-003 SHALL have parameter ACC_W, default 24, giving the accumulator/result width; it SHALL be at least 22.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, the reset; asynchronous, active-low.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the input beat handshake.
REQ-007 SHALL have ports in_first and in_last, input, 1 bit each, marking the first and last beats of an accumulation sequence.
REQ-008 SHALL have port mode, input, 2 bits: 00 int8, 01 int4, 10 int4-VSQ, 11 reserved.
REQ-009 SHALL have port vec_a, input, LANES*VEC_BITS bits, one row per lane with lane i at slice i.
REQ-010 SHALL have port vec_b, input, VEC_BITS bits, broadcast to all lanes.
REQ-011 SHALL have port scale_a, input, LANES*16 bits: per lane, 4 unsigned 4-bit group scales.
REQ-012 SHALL have port scale_b, input, 16 bits: 4 unsigned 4-bit group scales.
REQ-013 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the result handshake.
REQ-014 SHALL have port out_result, output, LANES*ACC_W bits, the signed per-lane results.
REQ-015 SHALL have port out_sat, output, LANES bits, the per-lane saturation flags.

Function
REQ-016 int8: lane dot SHALL equal the signed sum over 32 products per 256-bit chunk, summed across all chunks.
REQ-017 int4: lane dot SHALL equal the signed sum over all 4-bit element products.
REQ-018 int4-VSQ: each 256-bit chunk SHALL split into 4 groups of 16 int4 elements; group g partial SHALL be multiplied by scale_a[g]*scale_b[g] (unsigned) before summation.
REQ-019 Reserved mode SHALL produce a dot of 0; the beat still flows through the pipeline.
REQ-020 Dot values SHALL be held at 22 signed bits internally and sign-extended to ACC_W.
REQ-021 Pipeline: S1 registers per-lane dots; S2 accumulates.
REQ-022 Both pipeline stages SHALL advance only when adv = !(out_valid && !out_ready).
REQ-023 in_ready SHALL equal adv.
REQ-024 A beat with in_first SHALL load acc = dot; otherwise it SHALL load acc = acc + dot.
REQ-025 A beat with in_last SHALL copy the new acc into out_result and set out_valid on the same edge.
REQ-026 out_valid SHALL be observed two rising edges after acceptance of the last beat.
REQ-027 in_first and in_last both set SHALL form a single-beat sequence.
REQ-028 A beat without a preceding in_first SHALL accumulate onto the existing acc.
REQ-029 out_valid and out_result SHALL hold stable until out_ready is sampled high.
REQ-030 out_valid SHALL clear on that handshake unless a new last beat loads on the same edge, in which case it stays high with the new data.
REQ-031 Mode MAY change between beats; each beat SHALL use its own mode.

Reset
REQ-032 rst_n low SHALL asynchronously clear the S1 valid, S1 data, all accumulators, out_result, out_sat and out_valid.
REQ-033 in_ready SHALL read 1 during reset.
REQ-034 A sequence in flight at reset SHALL be discarded.

Configuration
REQ-035 Macro MAC_SAT_EN defined: accumulation SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-036 Macro MAC_SAT_EN defined: out_sat[i] SHALL be set when lane i clamped during the sequence; the flag is cleared by in_first.
REQ-037 Macro MAC_SAT_EN undefined: accumulation SHALL wrap modulo 2^ACC_W and out_sat SHALL be tied to 0.

Structure
REQ-038 Package mac_pkg SHALL hold the mode enum (MODE_INT8, MODE_INT4, MODE_VSQ, MODE_RSVD), DOT_W=22 and GROUP_ELEMS=16.
REQ-039 Sub-module mac_lane SHALL implement one lane (dot, scale, accumulate, saturate) and SHALL be instantiated LANES times by a generate loop.

Verification
REQ-040 int8, all a=b=0x7F, first+last -> every lane 32*16129=516128 after 2 edges.
REQ-041 int4, a=0x8 (-8), b=0x7, first+last -> every lane 64*-56=-3584.
REQ-042 VSQ, all elements 1, scale_a=scale_b=0xF per group -> 4*16*225=14400.
REQ-043 3-beat int4 sequence, dots 100, -30, 5 -> single result 75 with exactly one out_valid pulse.
REQ-044 out_ready low 5 cycles with a second sequence queued -> in_ready low, first result stable, no loss, second result follows in order.
REQ-045 With MAC_SAT_EN, int8 max positive x 20 beats -> result 8388607 and out_sat=1; without MAC_SAT_EN -> wrapped value and out_sat=0.
